msrv32_imm_encoder: RTL and testbench

MSRV32_IMM_ENCODER -- requirements
Module: msrv32_imm_encoder

---
 rtl/msrv32_imm_pkg.sv | 35 +++
 rtl/msrv32_imm_pack.sv | 60 ++++++
 rtl/msrv32_imm_encoder.sv | 108 ++++++++++
 tb/tb_msrv32_imm_encoder.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/msrv32_imm_pkg.sv
// Shared encodings for the RV32I immediate encoder: formats, FSM states,
// representable-range limits and the instruction-bit masks each format owns.
package msrv32_imm_pkg;

  typedef enum logic [2:0] {
    IMM_I   = 3'b000,
    IMM_S   = 3'b001,
    IMM_B   = 3'b010,
    IMM_U   = 3'b011,
    IMM_J   = 3'b100,
    IMM_CSR = 3'b101
  } imm_type_e;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'b00,
    ST_HOLD     = 2'b01,
    ST_SPLIT_HI = 2'b10
  } state_e;

  localparam int IS_MIN  = -2048;
  localparam int IS_MAX  = 2047;
  localparam int B_MIN   = -4096;
  localparam int B_MAX   = 4094;
  localparam int J_MIN   = -1048576;
  localparam int J_MAX   = 1048574;
  localparam int CSR_MIN = 0;
  localparam int CSR_MAX = 31;

  // Masks over instruction bits [31:7] (index 0 == instruction bit 7).
  localparam logic [24:0] OWN_I   = 25'h1FFE000;
  localparam logic [24:0] OWN_SB  = 25'h1FC001F;
  localparam logic [24:0] OWN_UJ  = 25'h1FFFFE0;
  localparam logic [24:0] OWN_CSR = 25'h0001F00;

endpackage

// File: rtl/msrv32_imm_pack.sv
// Combinational field placement and range check for one immediate format.
// Bits outside the format's field come straight from base; on error the field is zeroed.
module msrv32_imm_pack
  import msrv32_imm_pkg::*;
(
  input  logic [2:0]  imm_type,
  input  logic [31:0] imm,
  input  logic [24:0] base,
  output logic [24:0] bits,
  output logic        err
);

  logic signed [31:0] simm;
  logic [24:0]        own;
  logic [24:0]        fld;

  assign simm = imm;

  always_comb begin
    own = '0;
    fld = '0;
    err = 1'b0;
    case (imm_type)
      IMM_I: begin
        own = OWN_I;
        fld = {imm[11:0], 13'b0};
        err = !(simm >= IS_MIN && simm <= IS_MAX);
      end
      IMM_S: begin
        own = OWN_SB;
        fld = {imm[11:5], 13'b0, imm[4:0]};
        err = !(simm >= IS_MIN && simm <= IS_MAX);
      end
      IMM_B: begin
        own = OWN_SB;
        fld = {imm[12], imm[10:5], 13'b0, imm[4:1], imm[11]};
        err = !(simm >= B_MIN && simm <= B_MAX && !imm[0]);
      end
      IMM_U: begin
        own = OWN_UJ;
        fld = {imm[31:12], 5'b0};
        err = (imm[11:0] != 12'h000);
      end
      IMM_J: begin
        own = OWN_UJ;
        fld = {imm[20], imm[10:1], imm[11], imm[19:12], 5'b0};
        err = !(simm >= J_MIN && simm <= J_MAX && !imm[0]);
      end
      IMM_CSR: begin
        own = OWN_CSR;
        fld = {12'b0, imm[4:0], 8'b0};
        err = !(simm >= CSR_MIN && simm <= CSR_MAX);
      end
      default: err = 1'b1;
    endcase
  end

  assign bits = err ? (base & ~own) : ((base & ~own) | (fld & own));

endmodule

// File: rtl/msrv32_imm_encoder.sv
// Handshaked RV32I immediate encoder with a one-cycle output register.
// Define MSRV32_IMM_SPLIT_EN to turn out-of-range I-type requests into a U + I pair.
module msrv32_imm_encoder
  import msrv32_imm_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        valid_in,
  output logic        ready_out,
  input  logic [2:0]  imm_type_in,
  input  logic [31:0] imm_in,
  input  logic [24:0] base_in,
  output logic        valid_out,
  input  logic        ready_in,
  output logic [24:0] instr_out,
  output logic [2:0]  imm_type_out,
  output logic        last_out,
  output logic        err_out
);

  state_e      state, state_n;
  logic [24:0] pack_bits;
  logic        pack_err;
  logic [24:0] instr_n, lo_q, lo_n;
  logic [2:0]  type_n;
  logic        last_n, err_n;
  logic        accept, split_req;
  logic [19:0] hi_val;
  logic [24:0] hi_beat, lo_beat;

  msrv32_imm_pack u_pack (
    .imm_type (imm_type_in),
    .imm      (imm_in),
    .base     (base_in),
    .bits     (pack_bits),
    .err      (pack_err)
  );

  // (imm + 0x800) >> 12 reduces to rounding the upper 20 bits by imm[11].
  assign hi_val  = imm_in[31:12] + {19'b0, imm_in[11]};
  assign hi_beat = {hi_val, base_in[4:0]};
  assign lo_beat = {imm_in[11:0], base_in[4:0], base_in[7:0]};

`ifdef MSRV32_IMM_SPLIT_EN
  assign split_req = (imm_type_in == IMM_I) && pack_err;
`else
  assign split_req = 1'b0;
`endif

  assign valid_out = (state != ST_IDLE);
  assign ready_out = (state == ST_IDLE) || (state == ST_HOLD && ready_in && last_out);
  assign accept    = valid_in && ready_out;

  always_comb begin
    state_n = state;
    instr_n = instr_out;
    type_n  = imm_type_out;
    last_n  = last_out;
    err_n   = err_out;
    lo_n    = lo_q;
    case (state)
      ST_HOLD:     if (ready_in && !accept) state_n = ST_IDLE;
      ST_SPLIT_HI: if (ready_in) begin
        state_n = ST_HOLD;
        instr_n = lo_q;
        type_n  = IMM_I;
        last_n  = 1'b1;
        err_n   = 1'b0;
      end
      default: ;
    endcase
    if (accept) begin
      if (split_req) begin
        state_n = ST_SPLIT_HI;
        instr_n = hi_beat;
        type_n  = IMM_U;
        last_n  = 1'b0;
        err_n   = 1'b0;
        lo_n    = lo_beat;
      end else begin
        state_n = ST_HOLD;
        instr_n = pack_bits;
        type_n  = imm_type_in;
        last_n  = 1'b1;
        err_n   = pack_err;
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state        <= ST_IDLE;
      instr_out    <= '0;
      imm_type_out <= '0;
      last_out     <= 1'b0;
      err_out      <= 1'b0;
      lo_q         <= '0;
    end else begin
      state        <= state_n;
      instr_out    <= instr_n;
      imm_type_out <= type_n;
      last_out     <= last_n;
      err_out      <= err_n;
      lo_q         <= lo_n;
    end
  end

endmodule

// File: tb/tb_msrv32_imm_encoder.sv
// Directed bench for msrv32_imm_encoder; expectations are hand-computed constants.
// Covers both builds of MSRV32_IMM_SPLIT_EN.
module tb_msrv32_imm_encoder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        valid_in;
  logic        ready_out;
  logic [2:0]  imm_type_in;
  logic [31:0] imm_in;
  logic [24:0] base_in;
  logic        valid_out;
  logic        ready_in;
  logic [24:0] instr_out;
  logic [2:0]  imm_type_out;
  logic        last_out;
  logic        err_out;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  msrv32_imm_encoder dut (
    .clk_in       (clk_in),
    .rst_in       (rst_in),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .imm_type_in  (imm_type_in),
    .imm_in       (imm_in),
    .base_in      (base_in),
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .instr_out    (instr_out),
    .imm_type_out (imm_type_out),
    .last_out     (last_out),
    .err_out      (err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Present a request, wait (bounded) for ready_out, then take the accepting edge.
  task automatic send(input logic [2:0] t, input logic [31:0] imm, input logic [24:0] base);
    int unsigned n;
    imm_type_in = t;
    imm_in      = imm;
    base_in     = base;
    valid_in    = 1'b1;
    n = 0;
    while (!ready_out && n < 20) begin
      step();
      n++;
    end
    chk("accept_wait", {31'b0, n < 20}, 32'd1);
    step();
    valid_in = 1'b0;
  endtask

  task automatic chk_beat(input string tag, input logic [2:0] t, input logic [24:0] instr,
                          input logic last, input logic err);
    chk({tag, "_valid"}, {31'b0, valid_out}, 32'd1);
    chk({tag, "_type"},  {29'b0, imm_type_out}, {29'b0, t});
    chk({tag, "_instr"}, {7'b0, instr_out}, {7'b0, instr});
    chk({tag, "_last"},  {31'b0, last_out}, {31'b0, last});
    chk({tag, "_err"},   {31'b0, err_out}, {31'b0, err});
  endtask

  initial begin
    rst_in      = 1'b1;
    valid_in    = 1'b0;
    ready_in    = 1'b1;
    imm_type_in = 3'b000;
    imm_in      = '0;
    base_in     = '0;
    step();
    step();
    chk("rst_valid", {31'b0, valid_out}, 32'd0);
    chk("rst_instr", {7'b0, instr_out}, 32'd0);
    chk("rst_type",  {29'b0, imm_type_out}, 32'd0);
    chk("rst_last",  {31'b0, last_out}, 32'd0);
    chk("rst_err",   {31'b0, err_out}, 32'd0);
    chk("rst_ready", {31'b0, ready_out}, 32'd1);
    rst_in = 1'b0;
    step();

    // I-type -1: field [31:20] = 0xFFF
    send(3'b000, 32'hFFFF_FFFF, 25'h0);
    chk_beat("i_m1", 3'b000, 25'h1FFE000, 1'b1, 1'b0);
    chk("i_m1_ready", {31'b0, ready_out}, 32'd1);
    step();
    chk("i_m1_drain", {31'b0, valid_out}, 32'd0);

    // B-type 2048 lands only in instruction bit 7
    send(3'b010, 32'd2048, 25'h0);
    chk_beat("b_2048", 3'b010, 25'h0000001, 1'b1, 1'b0);
    step();
    send(3'b010, 32'd3, 25'h0);
    chk_beat("b_odd", 3'b010, 25'h0, 1'b1, 1'b1);
    step();
    send(3'b010, 32'd4096, 25'h0);
    chk_beat("b_over", 3'b010, 25'h0, 1'b1, 1'b1);
    step();

    // U-type with rd=5
    send(3'b011, 32'h1234_5000, 25'h5);
    chk_beat("u_rd5", 3'b011, 25'h02468A5, 1'b1, 1'b0);
    step();
    send(3'b011, 32'h1234_5001, 25'h5);
    chk_beat("u_low", 3'b011, 25'h0000005, 1'b1, 1'b1);
    step();

    // S-type boundaries
    send(3'b001, 32'hFFFF_F800, 25'h0);
    chk_beat("s_min", 3'b001, 25'h1000000, 1'b1, 1'b0);
    step();
    send(3'b001, 32'd2048, 25'h0);
    chk_beat("s_over", 3'b001, 25'h0, 1'b1, 1'b1);
    step();

    // J-type
    send(3'b100, 32'hFFFF_FFFE, 25'h0);
    chk_beat("j_m2", 3'b100, 25'h1FFFFE0, 1'b1, 1'b0);
    step();
    send(3'b100, 32'd1048576, 25'h0);
    chk_beat("j_over", 3'b100, 25'h0, 1'b1, 1'b1);
    step();

    // CSR
    send(3'b101, 32'd31, 25'h0);
    chk_beat("csr_31", 3'b101, 25'h0001F00, 1'b1, 1'b0);
    step();
    send(3'b101, 32'd32, 25'h0);
    chk_beat("csr_32", 3'b101, 25'h0, 1'b1, 1'b1);
    step();

    // Reserved type: error, base passes through whole
    send(3'b110, 32'd0, 25'h1234567);
    chk_beat("rsv", 3'b110, 25'h1234567, 1'b1, 1'b1);
    step();

    // Non-owned bits pass through
    send(3'b000, 32'd5, 25'h1FFFFFF);
    chk_beat("i_pass", 3'b000, 25'h000BFFF, 1'b1, 1'b0);
    step();

    // Backpressure: outputs stable, then one handshake only
    ready_in = 1'b0;
    send(3'b000, 32'd100, 25'h0);
    chk_beat("bp0", 3'b000, 25'h00C8000, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_beat("bp_hold", 3'b000, 25'h00C8000, 1'b1, 1'b0);
      chk("bp_ready", {31'b0, ready_out}, 32'd0);
    end
    ready_in = 1'b1;
    #1;
    chk("bp_ready_rel", {31'b0, ready_out}, 32'd1);
    step();
    chk("bp_once", {31'b0, valid_out}, 32'd0);

    // Back-to-back: one request per cycle
    imm_type_in = 3'b000; imm_in = 32'd1; base_in = 25'h0; valid_in = 1'b1;
    step();
    chk_beat("b2b_a", 3'b000, 25'h0002000, 1'b1, 1'b0);
    imm_type_in = 3'b101; imm_in = 32'd7;
    step();
    chk_beat("b2b_b", 3'b101, 25'h0000700, 1'b1, 1'b0);
    valid_in = 1'b0;
    step();
    chk("b2b_drain", {31'b0, valid_out}, 32'd0);

    // Out-of-range I-type
    send(3'b000, 32'h1234_5800, 25'h3);
`ifdef MSRV32_IMM_SPLIT_EN
    chk_beat("split_hi", 3'b011, 25'h02468C3, 1'b0, 1'b0);
    chk("split_ready", {31'b0, ready_out}, 32'd0);
    step();
    chk_beat("split_lo", 3'b000, 25'h1000303, 1'b1, 1'b0);
    step();
    chk("split_drain", {31'b0, valid_out}, 32'd0);
`else
    chk_beat("nosplit", 3'b000, 25'h0000003, 1'b1, 1'b1);
    step();
    chk("nosplit_drain", {31'b0, valid_out}, 32'd0);
`endif

    // Reset mid-beat (SPLIT_HI when split is built in) with a simultaneous request
    ready_in = 1'b0;
    send(3'b000, 32'h1234_5800, 25'h3);
    chk("pre_rst_valid", {31'b0, valid_out}, 32'd1);
    rst_in = 1'b1;
    imm_type_in = 3'b000; imm_in = 32'd1; base_in = 25'h0; valid_in = 1'b1;
    step();
    rst_in = 1'b0;
    valid_in = 1'b0;
    chk("mid_rst_valid", {31'b0, valid_out}, 32'd0);
    chk("mid_rst_instr", {7'b0, instr_out}, 32'd0);
    chk("mid_rst_ready", {31'b0, ready_out}, 32'd1);
    ready_in = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_rst_quiet", {31'b0, valid_out}, 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
